// File: rtl/fetch_queue.sv
// Instruction fetch with a DEPTH-entry prefetch queue, in-order variable-latency
// memory responses, EPC/branch redirect and stale-response discard.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            epc_taken_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            id_ready_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   MO_C    = CW'(MAX_OUT);
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_rpc;
    logic [XLEN-1:0] r_pc_q  [DEPTH];
    logic [XLEN-1:0] r_ins_q [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   r_disc;

    logic            w_redir;
    logic [XLEN-1:0] w_tgt;
    logic            w_rsp;
    logic            w_drop;
    logic            w_push;
    logic            w_valid;
    logic            w_pop;
    logic [CW:0]     w_used;
    logic            w_req;
    logic            w_take;

    assign w_redir = epc_taken_i | redirect_i;
    assign w_tgt   = epc_taken_i ? epc_i : redirect_pc_i;

    // Responses with nothing in flight belong to a request lost to reset.
    assign w_rsp   = imem_rvalid_i && (r_out != '0);
    assign w_drop  = w_rsp && (r_disc != '0);
    assign w_push  = w_rsp && !w_drop && !w_redir;
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && id_ready_i && !w_redir;

    // Queue slots plus in-flight requests never exceed DEPTH.
    assign w_used = {1'b0, r_count} + {1'b0, r_out};
    assign w_req  = !rst && !w_redir && (r_out < MO_C) && (w_used < DEPTH_C);
    assign w_take = w_req && imem_gnt_i;

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fpc;
    assign id_valid_o  = w_valid;
    assign id_instr_o  = w_valid ? r_ins_q[r_head] : NOP;
    assign id_pc_o     = w_valid ? r_pc_q[r_head] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_tail]  <= r_rpc;
            r_ins_q[r_tail] <= imem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc   <= RESET_PC;
            r_rpc   <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_out   <= '0;
            r_disc  <= '0;
        end else if (w_redir) begin
            r_fpc   <= w_tgt;
            r_rpc   <= w_tgt;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_out   <= r_out - CW'(w_rsp);
            // Everything still in flight was fetched down the old path.
            r_disc  <= r_out - CW'(w_rsp);
        end else begin
            if (w_take) begin
                r_fpc <= r_fpc + STEP;
            end
            r_out <= r_out + CW'(w_take) - CW'(w_rsp);
            if (w_drop) begin
                r_disc <= r_disc - CW'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
                r_rpc  <= r_rpc + STEP;
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule
